vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter H_BACK, default 88, hsync-trailing-edge-to-first-active-pixel clocks.
REQ-002 SHALL have parameter H_ACTIVE, default 800, active pixels per line.
REQ-003 SHALL have parameter V_BACK, default 23, vsync-trailing-edge-to-first-active-line lines.
REQ-004 SHALL have parameter V_ACTIVE, default 600, active lines per frame.
REQ-005 SHALL have parameter SYNC_POL, default 1, asserted level of hsync/vsync (1 = positive).
REQ-006 SHALL have parameter LOCK_FRAMES, default 2, consecutive stable frames required for lock.
REQ-007 SHALL have port clk40, input, 1, sole clock.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have ports hsync and vsync, input, 1 each, incoming sync.
REQ-010 SHALL have ports red, green and blue, input, 4 each, incoming pixel colour.
REQ-011 SHALL have ports pixR, pixG and pixB, output, 4 each, captured colour.
REQ-012 SHALL have port pixX, output, 10, active column 0..H_ACTIVE-1.
REQ-013 SHALL have port pixY, output, 10, active row 0..V_ACTIVE-1.
REQ-014 SHALL have port pixValid, output, 1, pixel outputs valid this cycle.
REQ-015 SHALL have port frameStart, output, 1, one-cycle pulse per vsync leading edge.
REQ-016 SHALL have port locked, output, 1, timing stable.
REQ-017 SHALL have ports hTotal and vTotal, output, 11 each, measured clocks/line and lines/frame.
REQ-018 SHALL have port frameSum, output, 16, per-frame pixel checksum.

Function
REQ-019 SHALL register all sync and colour inputs once (s1), then register s1 sync into s2; leading edge = s1 at SYNC_POL and s2 not.
REQ-020 SHALL run 11-bit hCount, zeroed on hsync leading edge, else +1, saturating at 2047.
REQ-021 SHALL latch hTotal = hCount+1 on each hsync leading edge; latch hsync width at hsync trailing edge.
REQ-022 SHALL run 11-bit vCount, zeroed on vsync leading edge, else +1 per hsync leading edge, saturating at 2047.
REQ-023 SHALL latch vTotal = vCount+1 on vsync leading edge; simultaneous h/v edges give vsync priority for vCount.
REQ-024 SHALL mark a cycle active when hCount lies in [hsyncWidth+H_BACK, +H_ACTIVE) and the line lies in [vsyncLines+V_BACK, +V_ACTIVE).
REQ-025 SHALL present pixR/G/B, pixX, pixY and pixValid registered, 2 cycles after the pin sample; pixX/pixY hold when pixValid=0.
REQ-026 SHALL implement lock FSM SEARCH, ACQUIRE, LOCKED: SEARCH->ACQUIRE on vsync edge; ACQUIRE counts frames whose every hTotal and vTotal equal the previous frame's, clearing the count on mismatch.
REQ-027 SHALL move ACQUIRE->LOCKED when count reaches LOCK_FRAMES; locked=1 only in LOCKED.
REQ-028 SHALL return to SEARCH (locked=0 next cycle) on any hTotal/vTotal mismatch or hCount saturation (sync loss).
REQ-029 SHALL gate pixValid with locked.

Reset
REQ-030 SHALL on rst_n low asynchronously clear all counters, outputs, s1/s2 to 0 and FSM to SEARCH; pixel data mid-line is discarded and lock restarts after release.

Configuration
REQ-031 SHALL with VGA_SYNC_DECODER_CHECKSUM_EN defined accumulate 16-bit wrapping sum of {r,g,b} (12 bit) over valid pixels, latched to frameSum at vsync leading edge and then cleared.
REQ-032 SHALL without VGA_SYNC_DECODER_CHECKSUM_EN drive frameSum constant 0 with no accumulator.

Structure
REQ-033 SHALL place the FSM state enum and 800x600@60 timing constants (1056, 128, 88, 628, 4, 23) in package vga_timing_pkg.
REQ-034 SHALL use one sub-module, sync_measure, instantiated twice (h and v) for edge detect, counter, width and total latch.

Verification
REQ-035 Clean 800x600@60 stream (sync 128/88, 4/23 lines) -> hTotal=1056, vTotal=628, locked=1 after 4th vsync edge.
REQ-036 Locked, first active pixel -> pixX=0, pixY=0, pixValid=1 exactly 2 cycles after hCount=216 on line 27.
REQ-037 Locked, one line lengthened to 1057 clocks -> locked=0 next cycle, relock after 4 clean vsync edges.
REQ-038 hsync held inactive 2048 clocks -> FSM SEARCH, locked=0, pixValid=0.
REQ-039 CHECKSUM_EN, constant colour 12'h001 full frame -> frameSum=16'h5300; without macro -> 0.
REQ-040 rst_n low mid-line -> all outputs 0 immediately, locked re-asserts only after 4 further vsync edges.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared lock-FSM state type, counter limits and the 800x600@60 reference timing.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_t;

  localparam int unsigned VGA_H_TOTAL = 1056;
  localparam int unsigned VGA_H_SYNC  = 128;
  localparam int unsigned VGA_H_BACK  = 88;
  localparam int unsigned VGA_V_TOTAL = 628;
  localparam int unsigned VGA_V_SYNC  = 4;
  localparam int unsigned VGA_V_BACK  = 23;

  localparam logic [10:0] CNT_MAX = '1;

endpackage

// File: rtl/sync_measure.sv
// Edge detect, saturating position counter, and pulse-width / period latch for one sync axis.
module sync_measure
  import vga_timing_pkg::*;
#(
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_s1,
  input  logic        i_s2,
  input  logic        i_step,
  output logic        o_lead,
  output logic [10:0] o_count,
  output logic [10:0] o_total,
  output logic [10:0] o_width,
  output logic        o_mismatch,
  output logic        o_sat
);

  logic        w_lead;
  logic        w_trail;
  logic        w_sat;
  logic [10:0] w_next;
  logic [10:0] r_count;
  logic [10:0] r_total;
  logic [10:0] r_width;

  assign w_lead  = (i_s1 == SYNC_POL) && (i_s2 != SYNC_POL);
  assign w_trail = (i_s1 != SYNC_POL) && (i_s2 == SYNC_POL);
  assign w_sat   = (r_count == CNT_MAX);
  // Count is zero-based from the leading edge, so period and width are count+1.
  assign w_next  = w_sat ? CNT_MAX : r_count + 11'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_total <= '0;
      r_width <= '0;
    end else begin
      if (w_lead)
        r_count <= '0;
      else if (i_step && !w_sat)
        r_count <= r_count + 11'd1;
      if (w_lead)
        r_total <= w_next;
      if (w_trail)
        r_width <= w_next;
    end
  end

  assign o_lead     = w_lead;
  assign o_count    = r_count;
  assign o_total    = r_total;
  assign o_width    = r_width;
  assign o_mismatch = w_lead && (w_next != r_total);
  assign o_sat      = w_sat;

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA sync timing recovery, lock tracking and active-pixel capture.
// Optional per-frame pixel checksum enabled by defining VGA_SYNC_DECODER_CHECKSUM_EN.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_BACK      = VGA_H_BACK,
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned V_BACK      = VGA_V_BACK,
  parameter int unsigned V_ACTIVE    = 600,
  parameter int unsigned SYNC_POL    = 1,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk40,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic [3:0]  pixR,
  output logic [3:0]  pixG,
  output logic [3:0]  pixB,
  output logic [9:0]  pixX,
  output logic [9:0]  pixY,
  output logic        pixValid,
  output logic        frameStart,
  output logic        locked,
  output logic [10:0] hTotal,
  output logic [10:0] vTotal,
  output logic [15:0] frameSum
);

  localparam bit         LP_POL  = (SYNC_POL != 0);
  localparam logic [7:0] LP_LOCK = 8'(LOCK_FRAMES);

  logic        r_hs1, r_vs1, r_hs2, r_vs2;
  logic [11:0] r_rgb1, r_rgb2, r_pix_rgb;
  logic        w_h_lead, w_v_lead, w_h_mis, w_v_mis, w_h_sat, w_v_sat;
  logic [10:0] w_hcount, w_vcount, w_hwidth, w_vwidth;
  logic [12:0] w_h_lo, w_h_hi, w_v_lo, w_v_hi;
  logic [9:0]  w_x, w_y;
  logic        w_active;
  logic        r_act1, r_pix_valid, r_frame_start;
  logic [9:0]  r_x1, r_y1, r_pix_x, r_pix_y;

  lock_state_t r_state, w_state_nxt;
  logic [7:0]  r_good, w_good_nxt;
  logic        r_bad, w_bad_nxt;

  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      r_hs1  <= 1'b0;
      r_vs1  <= 1'b0;
      r_hs2  <= 1'b0;
      r_vs2  <= 1'b0;
      r_rgb1 <= '0;
    end else begin
      r_hs1  <= hsync;
      r_vs1  <= vsync;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_rgb1 <= {red, green, blue};
    end
  end

  sync_measure #(.SYNC_POL(LP_POL)) u_hmeas (
    .i_clk(clk40), .i_rst_n(rst_n), .i_s1(r_hs1), .i_s2(r_hs2), .i_step(1'b1),
    .o_lead(w_h_lead), .o_count(w_hcount), .o_total(hTotal), .o_width(w_hwidth),
    .o_mismatch(w_h_mis), .o_sat(w_h_sat)
  );

  sync_measure #(.SYNC_POL(LP_POL)) u_vmeas (
    .i_clk(clk40), .i_rst_n(rst_n), .i_s1(r_vs1), .i_s2(r_vs2), .i_step(w_h_lead),
    .o_lead(w_v_lead), .o_count(w_vcount), .o_total(vTotal), .o_width(w_vwidth),
    .o_mismatch(w_v_mis), .o_sat(w_v_sat)
  );

  assign w_h_lo   = 13'(w_hwidth) + 13'(H_BACK);
  assign w_h_hi   = w_h_lo + 13'(H_ACTIVE);
  assign w_v_lo   = 13'(w_vwidth) + 13'(V_BACK);
  assign w_v_hi   = w_v_lo + 13'(V_ACTIVE);
  assign w_active = (13'(w_hcount) >= w_h_lo) && (13'(w_hcount) < w_h_hi) &&
                    (13'(w_vcount) >= w_v_lo) && (13'(w_vcount) < w_v_hi);
  assign w_x      = 10'(w_hcount - w_hwidth - 11'(H_BACK));
  assign w_y      = 10'(w_vcount - w_vwidth - 11'(V_BACK));

  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEARCH;
      r_good  <= '0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
      r_bad   <= w_bad_nxt;
    end
  end

  // The first frame after acquisition is only a reference; it is never counted as stable.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_bad_nxt   = r_bad | w_h_mis;
    case (r_state)
      SEARCH: begin
        if (w_v_lead) begin
          w_state_nxt = ACQUIRE;
          w_good_nxt  = '0;
          w_bad_nxt   = 1'b1;
        end
      end
      ACQUIRE: begin
        if (w_v_lead) begin
          w_bad_nxt = 1'b0;
          if (r_bad || w_h_mis || w_v_mis) begin
            w_good_nxt = '0;
          end else if (r_good + 8'd1 >= LP_LOCK) begin
            w_state_nxt = LOCKED;
            w_good_nxt  = '0;
          end else begin
            w_good_nxt = r_good + 8'd1;
          end
        end
      end
      LOCKED: begin
        if (w_h_mis || w_v_mis)
          w_state_nxt = SEARCH;
      end
      default: w_state_nxt = SEARCH;
    endcase
    if (w_h_sat || w_v_sat) begin
      w_state_nxt = SEARCH;
      w_good_nxt  = '0;
    end
  end

  assign locked = (r_state == LOCKED);

  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      r_act1        <= 1'b0;
      r_rgb2        <= '0;
      r_x1          <= '0;
      r_y1          <= '0;
      r_pix_valid   <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_pix_rgb     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_act1        <= w_active && locked;
      r_rgb2        <= r_rgb1;
      r_x1          <= w_x;
      r_y1          <= w_y;
      r_pix_valid   <= r_act1;
      r_frame_start <= w_v_lead;
      if (r_act1) begin
        r_pix_x   <= r_x1;
        r_pix_y   <= r_y1;
        r_pix_rgb <= r_rgb2;
      end
    end
  end

  assign pixValid   = r_pix_valid;
  assign pixX       = r_pix_x;
  assign pixY       = r_pix_y;
  assign pixR       = r_pix_rgb[11:8];
  assign pixG       = r_pix_rgb[7:4];
  assign pixB       = r_pix_rgb[3:0];
  assign frameStart = r_frame_start;

`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
  logic [15:0] r_acc, r_sum;

  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_sum <= '0;
    end else if (w_v_lead) begin
      r_sum <= r_acc;
      r_acc <= '0;
    end else if (r_act1) begin
      r_acc <= r_acc + 16'(r_rgb2);
    end
  end

  assign frameSum = r_sum;
`else
  assign frameSum = '0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down raster (38 clocks x 12 lines).
`timescale 1ns/1ps
module tb_vga_sync_decoder;

  localparam int HS = 8, HB = 6, HA = 20, HT = 38;
  localparam int VS = 2, VB = 3, VA = 5, VT = 12;
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk40 = 1'b0;
  logic        rst_n;
  logic        hsync, vsync;
  logic [3:0]  red, green, blue;
  logic [3:0]  pixR, pixG, pixB;
  logic [9:0]  pixX, pixY;
  logic        pixValid, frameStart, locked;
  logic [10:0] hTotal, vTotal;
  logic [15:0] frameSum;

  int          hpos, vpos, last_h, last_v, long_line;
  logic [11:0] colour;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk40 = ~clk40;

  vga_sync_decoder #(
    .H_BACK(HB), .H_ACTIVE(HA), .V_BACK(VB), .V_ACTIVE(VA),
    .SYNC_POL(1), .LOCK_FRAMES(2)
  ) dut (
    .clk40(clk40), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .pixR(pixR), .pixG(pixG), .pixB(pixB), .pixX(pixX), .pixY(pixY),
    .pixValid(pixValid), .frameStart(frameStart), .locked(locked),
    .hTotal(hTotal), .vTotal(vTotal), .frameSum(frameSum)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic gen_clock();
    int len;
    hsync = (hpos < HS);
    vsync = (vpos < VS);
    {red, green, blue} = colour;
    @(posedge clk40);
    #1;
    last_h = hpos;
    last_v = vpos;
    len = (vpos == long_line) ? HT + 1 : HT;
    if (hpos + 1 >= len) begin
      if (vpos == long_line) long_line = -1;
      hpos = 0;
      vpos = (vpos + 1 == VT) ? 0 : vpos + 1;
    end else begin
      hpos++;
    end
  endtask

  task automatic hold_clock();
    hsync = 1'b0;
    vsync = 1'b0;
    @(posedge clk40);
    #1;
  endtask

  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    do begin
      gen_clock();
      n++;
    end while (!(last_h == h && last_v == v) && n < 2000);
    chk("goto_reach", (last_h == h && last_v == v), 1);
  endtask

  task automatic relock(input string tag);
    for (int e = 1; e <= 4; e++) begin
      goto(0, 0);
      chk({tag, "_pre"}, locked, 0);
      gen_clock();
      chk({tag, "_lock"}, locked, (e == 4));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, pixValid, 0);
    chk({tag, "_x"}, pixX, 0);
    chk({tag, "_y"}, pixY, 0);
    chk({tag, "_rgb"}, {pixR, pixG, pixB}, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_htot"}, hTotal, 0);
    chk({tag, "_vtot"}, vTotal, 0);
    chk({tag, "_fstart"}, frameStart, 0);
    chk({tag, "_fsum"}, frameSum, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    hpos      = 20;
    vpos      = 6;
    long_line = -1;
    colour    = 12'h001;
    hsync     = 1'b0;
    vsync     = 1'b0;
    {red, green, blue} = '0;
    repeat (3) gen_clock();
    chk_all_zero("reset");
    rst_n = 1'b1;

    relock("lock0");
    chk("htotal", hTotal, HT);
    chk("vtotal", vTotal, VT);
    chk("fstart_pulse", frameStart, 1);
    chk("fsum_unlocked", frameSum, 0);

    goto(16, 5);
    chk("first_px_early", pixValid, 0);
    gen_clock();
    chk("first_px_valid", pixValid, 1);
    chk("first_px_x", pixX, 0);
    chk("first_px_y", pixY, 0);
    chk("first_px_b", pixB, 4'h1);
    chk("first_px_r", pixR, 4'h0);
    goto(36, 9);
    chk("last_px_valid", pixValid, 1);
    chk("last_px_x", pixX, HA - 1);
    chk("last_px_y", pixY, VA - 1);
    gen_clock();
    chk("after_last_valid", pixValid, 0);
    chk("after_last_xhold", pixX, HA - 1);

    goto(1, 0);
    chk("fstart_f5", frameStart, 1);
    chk("fsum_001", frameSum, CSUM_EN ? 32'h0064 : 32'h0);
    gen_clock();
    chk("fstart_clear", frameStart, 0);
    colour = 12'hFFF;
    goto(20, 7);
    chk("px_fff_r", pixR, 4'hF);
    goto(1, 0);
    chk("fsum_fff_wrap", frameSum, CSUM_EN ? 32'h3F9C : 32'h0);

    long_line = 3;
    goto(0, 4);
    chk("long_still_locked", locked, 1);
    gen_clock();
    chk("long_unlock", locked, 0);
    relock("relock_long");

    goto(0, 6);
    repeat (2048) hold_clock();
    chk("sat_not_yet", locked, 1);
    hold_clock();
    chk("sat_unlock", locked, 0);
    chk("sat_novalid", pixValid, 0);
    relock("relock_sat");

    goto(20, 6);
    chk("pre_rst_valid", pixValid, 1);
    chk("pre_rst_x", pixX, 3);
    chk("pre_rst_y", pixY, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midline_rst");
    repeat (3) gen_clock();
    rst_n = 1'b1;
    relock("relock_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
